// File: rtl/inv_bank_arbiter_if.sv
// Requester and inverter-bank signal bundle for inv_bank_arbiter.
// slave = arbiter side, master = requesters plus inverter bank side.
interface inv_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 6
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      busy;
    logic [DATA_W-1:0]         inv_a;
    logic [DATA_W-1:0]         inv_y;

    modport master (
        output req, req_data, inv_y,
        input  gnt, rsp_valid, rsp_data, busy, inv_a
    );

    modport slave (
        input  req, req_data, inv_y,
        output gnt, rsp_valid, rsp_data, busy, inv_a
    );
endinterface

// File: rtl/inv_bank_arbiter.sv
// Round-robin arbiter sharing one hex-inverter bank between NUM_REQ requesters.
// Define INV_BANK_CHECK_EN to build the sticky inv_y == ~inv_a checker.
module inv_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 6,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    inv_bank_arbiter_if.slave  bus,
    output logic               chk_err
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       sel_q, sel_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic [DATA_W-1:0]   inv_a_q, inv_a_d;

    logic                pick_vld;
    logic [PW-1:0]       pick;
    logic [PW-1:0]       idx;
    logic                cap;

    assign cap = (state_q == ST_SETTLE) && (cnt_q == '0);

    // Scan requests starting at ptr, wrapping by explicit compare.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && bus.req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
            idx = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Next-state and registered-output values for the transaction FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        rdat_d  = rdat_q;
        inv_a_d = inv_a_q;
        unique case (state_q)
            ST_IDLE: begin
                inv_a_d = '0;
                if (pick_vld) begin
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    inv_a_d      = bus.req_data[pick*DATA_W +: DATA_W];
                    sel_d        = pick;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = CW'(SETTLE - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cap) begin
                    rdat_d        = bus.inv_y;
                    vld_d         = '0;
                    vld_d[sel_q]  = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                vld_d   = '0;
                gnt_d   = '0;
                inv_a_d = '0;
                ptr_d   = (sel_q == PW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            rdat_q  <= '0;
            inv_a_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            rdat_q  <= rdat_d;
            inv_a_q <= inv_a_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_data  = rdat_q;
    assign bus.inv_a     = inv_a_q;
    assign bus.busy      = (state_q != ST_IDLE);

`ifdef INV_BANK_CHECK_EN
    logic chk_q;

    // Sticky flag: bank output disagreed with the driven operand at capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
        end else if (cap && (bus.inv_y != ~inv_a_q)) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_inv_bank_arbiter.sv
// Directed-vector bench for inv_bank_arbiter.
// Three instances cover SETTLE = 1, 3 and 4.
module tb_inv_bank_arbiter;
    localparam int N = 4;
    localparam int W = 6;

`ifdef INV_BANK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_c, rst_d;
    logic frc;
    logic err_a, err_c, err_d;
    int   nvec = 0;
    int   nerr = 0;
    int   s;

    logic [W-1:0] opt [4] = '{6'h00, 6'h3F, 6'h15, 6'h2A};
    logic [W-1:0] res [4] = '{6'h3F, 6'h00, 6'h2A, 6'h15};

    inv_bank_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) ia ();
    inv_bank_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) ic ();
    inv_bank_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) id ();

    assign ia.inv_y = frc ? '0 : ~ia.inv_a;
    assign ic.inv_y = ~ic.inv_a;
    assign id.inv_y = ~id.inv_a;

    inv_bank_arbiter #(.NUM_REQ(N), .DATA_W(W), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_a), .bus(ia), .chk_err(err_a)
    );
    inv_bank_arbiter #(.NUM_REQ(N), .DATA_W(W), .SETTLE(3)) u_c (
        .clk(clk), .rst_n(rst_c), .bus(ic), .chk_err(err_c)
    );
    inv_bank_arbiter #(.NUM_REQ(N), .DATA_W(W), .SETTLE(4)) u_d (
        .clk(clk), .rst_n(rst_d), .bus(id), .chk_err(err_d)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        frc = 1'b0;
        rst_a = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        ia.req = '0; ia.req_data = '0;
        ic.req = '0; ic.req_data = '0;
        id.req = '0; id.req_data = '0;
        tick(2);
        check("rst gnt", ia.gnt, 0);
        check("rst vld", ia.rsp_valid, 0);
        check("rst rdat", ia.rsp_data, 0);
        check("rst inv_a", ia.inv_a, 0);
        check("rst busy", ia.busy, 0);
        check("rst chk", err_a, 0);
        rst_a = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

        // single request, SETTLE=1
        ia.req_data[W-1:0] = 6'b101100;
        ia.req = 4'b0001;
        tick(1);
        check("t1 gnt", ia.gnt, 4'b0001);
        check("t1 inv_a", ia.inv_a, 6'b101100);
        check("t1 busy", ia.busy, 1);
        ia.req = '0;
        tick(1);
        check("t1 vld e1", ia.rsp_valid, 0);
        tick(1);
        check("t1 vld e2", ia.rsp_valid, 4'b0001);
        check("t1 rdat", ia.rsp_data, 6'b010011);
        tick(1);
        check("t1 vld e3", ia.rsp_valid, 0);
        check("t1 gnt e3", ia.gnt, 0);
        check("t1 busy e3", ia.busy, 0);

        // all four requesting continuously
        rst_a = 1'b0;
        tick(1);
        rst_a = 1'b1;
        ia.req_data = {6'h2A, 6'h15, 6'h3F, 6'h00};
        ia.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            s = k % 4;
            tick(1);
            check("t2 gnt", ia.gnt, 32'(4'b0001 << s));
            check("t2 inv_a", ia.inv_a, opt[s]);
            tick(2);
            check("t2 vld", ia.rsp_valid, 32'(4'b0001 << s));
            check("t2 rdat", ia.rsp_data, res[s]);
            if (k == 4) ia.req = '0;
            tick(1);
            check("t2 gnt off", ia.gnt, 0);
        end

        // requester 2 drops req after grant
        rst_a = 1'b0;
        tick(1);
        rst_a = 1'b1;
        ia.req_data = {6'h21, 6'h0F, 6'h00, 6'h00};
        ia.req = 4'b0100;
        tick(1);
        check("t3 gnt", ia.gnt, 4'b0100);
        tick(1);
        ia.req = 4'b1011;
        tick(1);
        check("t3 vld", ia.rsp_valid, 4'b0100);
        check("t3 rdat", ia.rsp_data, 6'h30);
        tick(2);
        check("t3 next gnt", ia.gnt, 4'b1000);
        check("t3 next inv_a", ia.inv_a, 6'h21);
        ia.req = '0;
        tick(2);
        check("t3 next vld", ia.rsp_valid, 4'b1000);
        check("t3 next rdat", ia.rsp_data, 6'h1E);
        tick(1);

        // bank fault: inv_y stuck at zero
        frc = 1'b1;
        ia.req = 4'b0001;
        tick(1);
        check("t4 gnt", ia.gnt, 4'b0001);
        check("t4 chk pre", err_a, 0);
        ia.req = '0;
        tick(2);
        check("t4 rdat", ia.rsp_data, 6'h00);
        check("t4 chk", err_a, 32'(CHK));
        frc = 1'b0;
        tick(1);
        ia.req_data[W +: W] = 6'h15;
        ia.req = 4'b0010;
        tick(1);
        check("t4 gnt2", ia.gnt, 4'b0010);
        ia.req = '0;
        tick(2);
        check("t4 rdat2", ia.rsp_data, 6'h2A);
        check("t4 chk held", err_a, 32'(CHK));
        tick(1);
        rst_a = 1'b0;
        tick(1);
        check("t4 chk rst", err_a, 0);
        rst_a = 1'b1;

        // SETTLE=3 latency
        ic.req_data[2*W +: W] = 6'h01;
        ic.req = 4'b0100;
        tick(1);
        check("t5 gnt", ic.gnt, 4'b0100);
        ic.req = '0;
        tick(3);
        check("t5 vld early", ic.rsp_valid, 0);
        check("t5 busy", ic.busy, 1);
        tick(1);
        check("t5 vld", ic.rsp_valid, 4'b0100);
        check("t5 rdat", ic.rsp_data, 6'h3E);
        tick(1);
        check("t5 vld off", ic.rsp_valid, 0);
        check("t5 busy off", ic.busy, 0);
        check("t5 chk", err_c, 0);

        // SETTLE=4: full transaction, then reset mid-SETTLE
        id.req_data = {6'h00, 6'h2C, 6'h3A, 6'h00};
        id.req = 4'b0010;
        tick(1);
        check("t6 gnt", id.gnt, 4'b0010);
        id.req = '0;
        tick(5);
        check("t6 vld", id.rsp_valid, 4'b0010);
        check("t6 rdat", id.rsp_data, 6'h05);
        tick(1);
        id.req = 4'b0100;
        tick(1);
        check("t6 gnt2", id.gnt, 4'b0100);
        id.req = '0;
        tick(3);
        check("t6 busy mid", id.busy, 1);
        rst_d = 1'b0;
        tick(1);
        check("t6 rst gnt", id.gnt, 0);
        check("t6 rst inv_a", id.inv_a, 0);
        check("t6 rst busy", id.busy, 0);
        check("t6 rst vld", id.rsp_valid, 0);
        rst_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("t6 no vld", id.rsp_valid, 0);
        end
        id.req = 4'b1010;
        tick(1);
        check("t6 ptr0 gnt", id.gnt, 4'b0010);
        id.req = '0;
        tick(6);
        check("t6 idle", id.busy, 0);
        id.req = 4'b1000;
        tick(1);
        check("t6 gnt3", id.gnt, 4'b1000);
        id.req = '0;
        tick(5);
        check("t6 vld3", id.rsp_valid, 4'b1000);
        check("t6 chk", err_d, 0);
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
